// File: rtl/fpnew_result_rob_if.sv
// Handshake bundle for fpnew_result_rob: issue-side allocation,
// per-opgroup completion channels and the in-order result port.
interface fpnew_result_rob_if #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = 8,
  parameter int unsigned TagWidth = 1
);
  localparam int unsigned IdxW = $clog2(Depth);

  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [TagWidth-1:0]   alloc_tag_i;
  logic [IdxW-1:0]       alloc_id_o;

  logic [NumIn-1:0]       cpl_valid_i;
  logic [NumIn-1:0]       cpl_ready_o;
  logic [NumIn*IdxW-1:0]  cpl_id_i;
  logic [NumIn*Width-1:0] cpl_result_i;
  logic [NumIn*5-1:0]     cpl_status_i;

  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [Width-1:0]      result_o;
  logic [4:0]            status_o;
  logic [TagWidth-1:0]   tag_o;

  modport master (
    output alloc_valid_i, alloc_tag_i,
    input  alloc_ready_o, alloc_id_o,
    output cpl_valid_i, cpl_id_i,
    output cpl_result_i, cpl_status_i,
    input  cpl_ready_o,
    input  out_valid_o, result_o,
    input  status_o, tag_o,
    output out_ready_i
  );

  modport slave (
    input  alloc_valid_i, alloc_tag_i,
    output alloc_ready_o, alloc_id_o,
    input  cpl_valid_i, cpl_id_i,
    input  cpl_result_i, cpl_status_i,
    output cpl_ready_o,
    output out_valid_o, result_o,
    output status_o, tag_o,
    input  out_ready_i
  );
endinterface

// File: rtl/fpnew_result_rob.sv
// In-order completion buffer for FPU opgroup results.
// FPNEW_ROB_STICKY_FLAGS_EN enables the sticky fflags register.
module fpnew_result_rob #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = 8,
  parameter int unsigned TagWidth = 1,
  parameter int unsigned IdxW     = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  fpnew_result_rob_if.slave io,
  output logic              busy_o,
  output logic [IdxW:0]     count_o,
  output logic [4:0]        fflags_o,
  input  logic              fflags_clr_i
);

  logic [IdxW-1:0]     head_q;
  logic [IdxW-1:0]     tail_q;
  logic [IdxW:0]       count_q;
  logic [Depth-1:0]    alloc_q;
  logic [Depth-1:0]    done_q;
  logic [Width-1:0]    result_q [Depth];
  logic [4:0]          status_q [Depth];
  logic [TagWidth-1:0] tag_q    [Depth];

  logic             alloc_fire;
  logic             retire_fire;
  logic [Depth-1:0] cpl_hit;
  logic [Depth-1:0] cpl_we;
  logic [Width-1:0] cpl_res [Depth];
  logic [4:0]       cpl_st  [Depth];

  assign io.alloc_ready_o = count_q < (IdxW+1)'(Depth);
  assign io.alloc_id_o    = tail_q;
  assign io.cpl_ready_o   = '1;

  assign io.out_valid_o = alloc_q[head_q] & done_q[head_q];
  assign io.result_o    = result_q[head_q];
  assign io.status_o    = status_q[head_q];
  assign io.tag_o       = tag_q[head_q];

  assign busy_o  = count_q != '0;
  assign count_o = count_q;

  assign alloc_fire  = io.alloc_valid_i & io.alloc_ready_o;
  assign retire_fire = io.out_valid_o & io.out_ready_i;

  // Scan channels high-to-low so the lowest index wins a shared ID.
  always_comb begin
    for (int j = 0; j < Depth; j++) begin
      cpl_hit[j] = 1'b0;
      cpl_res[j] = '0;
      cpl_st[j]  = '0;
      for (int k = NumIn-1; k >= 0; k--) begin
        if (io.cpl_valid_i[k] &&
            io.cpl_id_i[k*IdxW +: IdxW] == IdxW'(j)) begin
          cpl_hit[j] = 1'b1;
          cpl_res[j] = io.cpl_result_i[k*Width +: Width];
          cpl_st[j]  = io.cpl_status_i[k*5 +: 5];
        end
      end
      cpl_we[j] = cpl_hit[j] & alloc_q[j] &
                  ~done_q[j] & ~flush_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      if (alloc_fire) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + IdxW'(1);
      end
      for (int j = 0; j < Depth; j++) begin
        if (cpl_we[j]) done_q[j] <= 1'b1;
      end
      if (retire_fire) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + IdxW'(1);
      end
      count_q <= count_q + (IdxW+1)'(alloc_fire)
                         - (IdxW+1)'(retire_fire);
    end
  end

  // Payload storage is only cleared by reset; flush drops the valid bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < Depth; j++) begin
        result_q[j] <= '0;
        status_q[j] <= '0;
        tag_q[j]    <= '0;
      end
    end else begin
      if (alloc_fire) tag_q[tail_q] <= io.alloc_tag_i;
      for (int j = 0; j < Depth; j++) begin
        if (cpl_we[j]) begin
          result_q[j] <= cpl_res[j];
          status_q[j] <= cpl_st[j];
        end
      end
    end
  end

`ifdef FPNEW_ROB_STICKY_FLAGS_EN
  logic [4:0] fflags_q;
  logic       flag_fire;

  assign flag_fire = retire_fire & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_q <= flag_fire ? io.status_o : 5'd0;
    end else if (flag_fire) begin
      fflags_q <= fflags_q | io.status_o;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic unused_fflags_clr;

  assign unused_fflags_clr = fflags_clr_i;
  assign fflags_o          = '0;
`endif

endmodule

// File: tb/tb_fpnew_result_rob.sv
// Directed bench for fpnew_result_rob (Depth=4, NumIn=2, TagWidth=2).
module tb_fpnew_result_rob;
  localparam int unsigned NI = 2;
  localparam int unsigned W  = 64;
  localparam int unsigned D  = 4;
  localparam int unsigned TW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       busy;
  logic [2:0] count;
  logic [4:0] fflags;
  logic       fflags_clr;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  fpnew_result_rob_if #(
    .NumIn(NI), .Width(W), .Depth(D), .TagWidth(TW)
  ) bus ();

  fpnew_result_rob #(
    .NumIn(NI), .Width(W), .Depth(D), .TagWidth(TW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .io          (bus),
    .busy_o      (busy),
    .count_o     (count),
    .fflags_o    (fflags),
    .fflags_clr_i(fflags_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_cpl();
    bus.cpl_valid_i  = '0;
    bus.cpl_id_i     = '0;
    bus.cpl_result_i = '0;
    bus.cpl_status_i = '0;
  endtask

  task automatic cpl(input int ch, input logic [1:0] id,
                     input logic [63:0] r, input logic [4:0] st);
    bus.cpl_valid_i[ch]         = 1'b1;
    bus.cpl_id_i[ch*2 +: 2]     = id;
    bus.cpl_result_i[ch*64 +: 64] = r;
    bus.cpl_status_i[ch*5 +: 5] = st;
  endtask

  task automatic reset_dut();
    flush = 1'b0;
    fflags_clr = 1'b0;
    bus.alloc_valid_i = 1'b0;
    bus.alloc_tag_i = '0;
    bus.out_ready_i = 1'b0;
    clr_cpl();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_tag_i = TW'(i + 1);
      cyc();
    end
    bus.alloc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    total_cnt++; if (bus.out_valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", bus.out_valid_o); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (bus.alloc_ready_o !== 1'b1) $display("FAIL rst_ready got %0b want 1", bus.alloc_ready_o); else pass_cnt++;
    total_cnt++; if (bus.result_o !== 64'd0) $display("FAIL rst_result got %h want 0", bus.result_o); else pass_cnt++;
    total_cnt++; if (fflags !== 5'd0) $display("FAIL rst_fflags got %h want 0", fflags); else pass_cnt++;
  endtask

  task automatic test_in_order();
    reset_dut();
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid_i = 1'b1;
      bus.alloc_tag_i = TW'(i + 1);
      total_cnt++; if (bus.alloc_id_o !== 2'(i)) $display("FAIL io_id got %0d want %0d", bus.alloc_id_o, i); else pass_cnt++;
      cyc();
    end
    bus.alloc_valid_i = 1'b0;
    total_cnt++; if (count !== 3'd3) $display("FAIL io_count got %0d want 3", count); else pass_cnt++;
    cpl(1, 2'd2, 64'hC, 5'd0);
    cyc();
    clr_cpl();
    total_cnt++; if (bus.out_valid_o !== 1'b0) $display("FAIL io_early got %0b want 0", bus.out_valid_o); else pass_cnt++;
    cpl(0, 2'd0, 64'hA, 5'd0);
    total_cnt++; if (bus.out_valid_o !== 1'b0) $display("FAIL io_bypass got %0b want 0", bus.out_valid_o); else pass_cnt++;
    cyc();
    clr_cpl();
    total_cnt++; if (bus.out_valid_o !== 1'b1 || bus.result_o !== 64'hA || bus.tag_o !== 2'd1) $display("FAIL io_first got v%0b %h t%0d want v1 a t1", bus.out_valid_o, bus.result_o, bus.tag_o); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.out_valid_o !== 1'b0) $display("FAIL io_hold got %0b want 0", bus.out_valid_o); else pass_cnt++;
    cpl(0, 2'd1, 64'hB, 5'd0);
    cyc();
    clr_cpl();
    total_cnt++; if (bus.out_valid_o !== 1'b1 || bus.result_o !== 64'hB || bus.tag_o !== 2'd2) $display("FAIL io_second got v%0b %h t%0d want v1 b t2", bus.out_valid_o, bus.result_o, bus.tag_o); else pass_cnt++;
    cyc();
    total_cnt++; if (bus.out_valid_o !== 1'b1 || bus.result_o !== 64'hC || bus.tag_o !== 2'd3) $display("FAIL io_third got v%0b %h t%0d want v1 c t3", bus.out_valid_o, bus.result_o, bus.tag_o); else pass_cnt++;
    cyc();
    total_cnt++; if (count !== 3'd0 || busy !== 1'b0 || bus.out_valid_o !== 1'b0) $display("FAIL io_empty got c%0d b%0b v%0b want 0 0 0", count, busy, bus.out_valid_o); else pass_cnt++;
  endtask

  task automatic test_full();
    reset_dut();
    alloc_n(4);
    total_cnt++; if (bus.alloc_ready_o !== 1'b0) $display("FAIL full_ready got %0b want 0", bus.alloc_ready_o); else pass_cnt++;
    total_cnt++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else pass_cnt++;
    cpl(0, 2'd0, 64'h5, 5'd0);
    cyc();
    clr_cpl();
    bus.out_ready_i = 1'b1;
    bus.alloc_valid_i = 1'b1;
    bus.alloc_tag_i = 2'd3;
    total_cnt++; if (bus.out_valid_o !== 1'b1 || bus.alloc_ready_o !== 1'b0) $display("FAIL full_retire got v%0b r%0b want v1 r0", bus.out_valid_o, bus.alloc_ready_o); else pass_cnt++;
    cyc();
    bus.out_ready_i = 1'b0;
    total_cnt++; if (bus.alloc_ready_o !== 1'b1 || count !== 3'd3) $display("FAIL full_free got r%0b c%0d want r1 c3", bus.alloc_ready_o, count); else pass_cnt++;
    total_cnt++; if (bus.alloc_id_o !== 2'd0) $display("FAIL full_wrap got %0d want 0", bus.alloc_id_o); else pass_cnt++;
    cyc();
    bus.alloc_valid_i = 1'b0;
    total_cnt++; if (count !== 3'd4 || bus.alloc_ready_o !== 1'b0) $display("FAIL full_refill got c%0d r%0b want c4 r0", count, bus.alloc_ready_o); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    reset_dut();
    alloc_n(1);
    cpl(0, 2'd0, 64'h1234_5678_9abc_def0, 5'h3);
    cyc();
    clr_cpl();
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (bus.out_valid_o !== 1'b1 || bus.result_o !== 64'h1234_5678_9abc_def0) $display("FAIL bp_hold%0d got v%0b %h want v1 123456789abcdef0", i, bus.out_valid_o, bus.result_o); else pass_cnt++;
      cyc();
    end
    bus.out_ready_i = 1'b1;
    total_cnt++; if (bus.status_o !== 5'h3 || bus.tag_o !== 2'd1) $display("FAIL bp_meta got s%h t%0d want s03 t1", bus.status_o, bus.tag_o); else pass_cnt++;
    cyc();
    bus.out_ready_i = 1'b0;
    total_cnt++; if (bus.out_valid_o !== 1'b0 || count !== 3'd0) $display("FAIL bp_retire got v%0b c%0d want v0 c0", bus.out_valid_o, count); else pass_cnt++;
  endtask

  task automatic test_conflict();
    reset_dut();
    alloc_n(1);
    cpl(0, 2'd0, 64'h1, 5'h01);
    cpl(1, 2'd0, 64'h2, 5'h10);
    cyc();
    clr_cpl();
    total_cnt++; if (bus.out_valid_o !== 1'b1 || bus.result_o !== 64'h1 || bus.status_o !== 5'h01) $display("FAIL cf_win got v%0b %h s%h want v1 1 s01", bus.out_valid_o, bus.result_o, bus.status_o); else pass_cnt++;
    cpl(1, 2'd0, 64'h7, 5'h1f);
    cyc();
    clr_cpl();
    total_cnt++; if (bus.result_o !== 64'h1) $display("FAIL cf_done got %h want 1", bus.result_o); else pass_cnt++;
    bus.out_ready_i = 1'b1;
    cyc();
    bus.out_ready_i = 1'b0;
    cpl(0, 2'd3, 64'h9, 5'd0);
    cyc();
    clr_cpl();
    cyc();
    total_cnt++; if (bus.out_valid_o !== 1'b0 || count !== 3'd0) $display("FAIL cf_unalloc got v%0b c%0d want v0 c0", bus.out_valid_o, count); else pass_cnt++;
    total_cnt++; if (bus.alloc_id_o !== 2'd1) $display("FAIL cf_tail got %0d want 1", bus.alloc_id_o); else pass_cnt++;
  endtask

  task automatic test_flush();
    reset_dut();
    alloc_n(3);
    cpl(0, 2'd0, 64'hA, 5'd0);
    cyc();
    clr_cpl();
    total_cnt++; if (bus.out_valid_o !== 1'b1) $display("FAIL fl_pre got %0b want 1", bus.out_valid_o); else pass_cnt++;
    flush = 1'b1;
    bus.alloc_valid_i = 1'b1;
    cyc();
    flush = 1'b0;
    bus.alloc_valid_i = 1'b0;
    total_cnt++; if (count !== 3'd0 || busy !== 1'b0) $display("FAIL fl_count got c%0d b%0b want c0 b0", count, busy); else pass_cnt++;
    total_cnt++; if (bus.out_valid_o !== 1'b0 || bus.alloc_id_o !== 2'd0) $display("FAIL fl_state got v%0b id%0d want v0 id0", bus.out_valid_o, bus.alloc_id_o); else pass_cnt++;
    cpl(0, 2'd1, 64'hB, 5'd0);
    cyc();
    clr_cpl();
    alloc_n(2);
    cyc();
    total_cnt++; if (bus.out_valid_o !== 1'b0 || count !== 3'd2) $display("FAIL fl_stale got v%0b c%0d want v0 c2", bus.out_valid_o, count); else pass_cnt++;
  endtask

  task automatic test_sticky_flags();
    logic [4:0] exp_acc;
    logic [4:0] exp_both;
    logic [4:0] exp_zero;
`ifdef FPNEW_ROB_STICKY_FLAGS_EN
    exp_acc  = 5'h11;
    exp_both = 5'h04;
`else
    exp_acc  = 5'h00;
    exp_both = 5'h00;
`endif
    exp_zero = 5'h00;
    reset_dut();
    alloc_n(2);
    cpl(0, 2'd0, 64'h1, 5'h01);
    cpl(1, 2'd1, 64'h2, 5'h10);
    cyc();
    clr_cpl();
    bus.out_ready_i = 1'b1;
    cyc();
    cyc();
    bus.out_ready_i = 1'b0;
    total_cnt++; if (fflags !== exp_acc) $display("FAIL ff_acc got %h want %h", fflags, exp_acc); else pass_cnt++;
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    total_cnt++; if (fflags !== exp_zero) $display("FAIL ff_clr got %h want %h", fflags, exp_zero); else pass_cnt++;
    alloc_n(1);
    cpl(0, 2'd2, 64'h3, 5'h04);
    cyc();
    clr_cpl();
    alloc_n(1);
    cpl(0, 2'd3, 64'h4, 5'h08);
    cyc();
    clr_cpl();
    fflags_clr = 1'b1;
    bus.out_ready_i = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    bus.out_ready_i = 1'b0;
    total_cnt++; if (fflags !== exp_both) $display("FAIL ff_clr_ret got %h want %h", fflags, exp_both); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fflags_clr = 1'b0;
    bus.alloc_valid_i = 1'b0;
    bus.alloc_tag_i = '0;
    bus.out_ready_i = 1'b0;
    clr_cpl();
    test_reset();
    test_in_order();
    test_full();
    test_backpressure();
    test_conflict();
    test_flush();
    test_sticky_flags();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
